// File: rtl/n1_prog_loader.sv
// n1_prog_loader: byte-stream front end for the n1 core.
// Decodes load frames into program/data RAM write strobes and gates core_run.
// Optional checksum trailer per load frame: define N1_LOADER_CKSUM_EN.
module n1_prog_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              prog_we,
   output logic [ADDR_W-1:0] prog_addr,
   output logic [15:0]       prog_wdata,
   output logic              data_we,
   output logic [ADDR_W-1:0] data_addr,
   output logic [7:0]        data_wdata,
   output logic              core_run,
   output logic              busy,
   output logic              err
);

   localparam int CW = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_CNT,
      S_HI,
      S_LO,
      S_DB,
      S_CSUM
   } state_t;

`ifdef N1_LOADER_CKSUM_EN
   localparam state_t S_END = S_CSUM;
`else
   localparam state_t S_END = S_IDLE;
`endif

   state_t            state_q, state_d;
   logic              settled_q;
   logic              xfer;
   logic              hdr_ok;
   logic              last_word;
   logic              is_prog_q, is_prog_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CW-1:0]     rem_q, rem_d;
   logic [7:0]        hi_q, hi_d;
   logic              prog_we_d, data_we_d;
   logic [ADDR_W-1:0] prog_addr_d, data_addr_d;
   logic [15:0]       prog_wdata_d;
   logic [7:0]        data_wdata_d;
   logic              core_run_d, busy_d, err_d;
`ifdef N1_LOADER_CKSUM_EN
   logic [7:0]        sum_q, sum_d;
   logic              lock_q, lock_d;
`endif

   // settled_q is the only gate on byte_ready besides ena: low for one cycle after reset
   assign byte_ready = ena & settled_q;
   assign xfer       = byte_valid & byte_ready;
   assign hdr_ok     = (byte_in[5:0] == 6'd0);
   assign last_word  = (rem_q == CW'(1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         settled_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         settled_q <= settled_q | ena;
      end
   end

   // Next-state decode: advance only on an accepted byte
   always_comb begin
      state_d = state_q;
      if (xfer) begin
         unique case (state_q)
            S_IDLE: if (hdr_ok && !byte_in[7]) state_d = S_ADDR;
            S_ADDR: state_d = S_CNT;
            S_CNT:  state_d = is_prog_q ? S_HI : S_DB;
            S_HI:   state_d = S_LO;
            S_LO:   state_d = last_word ? S_END : S_HI;
            S_DB:   state_d = last_word ? S_END : S_DB;
            S_CSUM: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output/datapath decode: next values for every registered output
   always_comb begin
      is_prog_d    = is_prog_q;
      addr_d       = addr_q;
      rem_d        = rem_q;
      hi_d         = hi_q;
      prog_we_d    = 1'b0;
      prog_addr_d  = prog_addr;
      prog_wdata_d = prog_wdata;
      data_we_d    = 1'b0;
      data_addr_d  = data_addr;
      data_wdata_d = data_wdata;
      core_run_d   = core_run;
      err_d        = err;
`ifdef N1_LOADER_CKSUM_EN
      sum_d        = sum_q;
      lock_d       = lock_q;
`endif
      if (xfer) begin
         unique case (state_q)
            S_IDLE: begin
               if (!hdr_ok) begin
                  err_d = 1'b1;
               end else begin
                  unique case (byte_in[7:6])
                     2'b00: begin is_prog_d = 1'b1; core_run_d = 1'b0; end
                     2'b01: begin is_prog_d = 1'b0; core_run_d = 1'b0; end
`ifdef N1_LOADER_CKSUM_EN
                     2'b10: if (!lock_q) core_run_d = 1'b1;
`else
                     2'b10: core_run_d = 1'b1;
`endif
                     default: core_run_d = 1'b0;
                  endcase
               end
            end
            S_ADDR: begin
               addr_d = byte_in[ADDR_W-1:0];
`ifdef N1_LOADER_CKSUM_EN
               sum_d  = byte_in;
`endif
            end
            S_CNT: begin
               // zero count encodes a full 2^ADDR_W-word frame
               rem_d = (byte_in[ADDR_W-1:0] == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                                   : {1'b0, byte_in[ADDR_W-1:0]};
`ifdef N1_LOADER_CKSUM_EN
               sum_d = sum_q + byte_in;
`endif
            end
            S_HI: begin
               hi_d = byte_in;
`ifdef N1_LOADER_CKSUM_EN
               sum_d = sum_q + byte_in;
`endif
            end
            S_LO: begin
               prog_we_d    = 1'b1;
               prog_addr_d  = addr_q;
               prog_wdata_d = {hi_q, byte_in};
               addr_d       = addr_q + ADDR_W'(1);
               rem_d        = rem_q - CW'(1);
`ifdef N1_LOADER_CKSUM_EN
               sum_d        = sum_q + byte_in;
`endif
            end
            S_DB: begin
               data_we_d    = 1'b1;
               data_addr_d  = addr_q;
               data_wdata_d = byte_in;
               addr_d       = addr_q + ADDR_W'(1);
               rem_d        = rem_q - CW'(1);
`ifdef N1_LOADER_CKSUM_EN
               sum_d        = sum_q + byte_in;
`endif
            end
            S_CSUM: begin
`ifdef N1_LOADER_CKSUM_EN
               if (byte_in != sum_q) begin
                  err_d  = 1'b1;
                  lock_d = 1'b1;
               end
`endif
            end
            default: ;
         endcase
      end
      busy_d = (state_d != S_IDLE);
   end

   // Output and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_prog_q  <= 1'b0;
         addr_q     <= '0;
         rem_q      <= '0;
         hi_q       <= '0;
         prog_we    <= 1'b0;
         prog_addr  <= '0;
         prog_wdata <= '0;
         data_we    <= 1'b0;
         data_addr  <= '0;
         data_wdata <= '0;
         core_run   <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
`ifdef N1_LOADER_CKSUM_EN
         sum_q      <= '0;
         lock_q     <= 1'b0;
`endif
      end else begin
         is_prog_q  <= is_prog_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         hi_q       <= hi_d;
         prog_we    <= prog_we_d;
         prog_addr  <= prog_addr_d;
         prog_wdata <= prog_wdata_d;
         data_we    <= data_we_d;
         data_addr  <= data_addr_d;
         data_wdata <= data_wdata_d;
         core_run   <= core_run_d;
         busy       <= busy_d;
         err        <= err_d;
`ifdef N1_LOADER_CKSUM_EN
         sum_q      <= sum_d;
         lock_q     <= lock_d;
`endif
      end
   end

endmodule

// File: doc/n1_prog_loader.md
Name: n1_prog_loader

Overview:
- Front-end loader that sits directly upstream of the n1 core.
- Receives a byte stream from the chip input pins through a valid/ready handshake. Decodes frames that write 16-bit instructions into program RAM or 8-bit words into data RAM, and gates the core's run enable.
- Drives the core's memory write ports; the core's program counter starts only after core_run is asserted.

Parameters:
- ADDR_W, 8, width of the program/data RAM addresses; legal range 1..8. The address byte uses its low ADDR_W bits only.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  when low, freezes all state and holds byte_ready low
- byte_in  in  8  stream byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  loader can accept a byte; a transfer occurs when valid&&ready at a rising edge
- prog_we  out  1  one-cycle program RAM write strobe
- prog_addr  out  ADDR_W  program RAM write address
- prog_wdata  out  16  program RAM write data
- data_we  out  1  one-cycle data RAM write strobe
- data_addr  out  ADDR_W  data RAM write address
- data_wdata  out  8  data RAM write data
- core_run  out  1  core enable; the core's PC is held while this is low
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky error flag; cleared only by reset

Behaviour:
- All outputs are registered. Reset values: byte_ready=0, all strobes/addresses/data=0, core_run=0, busy=0, err=0, state=IDLE. Reset mid-frame aborts the frame; no partial write is issued.
- byte_ready = ena && (state != RST_SETTLE). It is 0 in the single cycle after reset release and 1 thereafter. The loader never back-pressures while enabled.
- Header byte, bits [7:6]:
  - 00 = program load
  - 01 = data load
  - 10 = RUN
  - 11 = HALT
- Header bits [5:0] must be 0. Otherwise err is set and the loader stays in IDLE, so the next byte is treated as a header.
- RUN: core_run goes to 1 in the cycle after the header is accepted. HALT: core_run goes to 0 in the cycle after. Repeated RUN or HALT is idempotent.
- A program-load or data-load header clears core_run in the next cycle (halt-on-load). It is never automatically re-asserted.
- Load frame: header -> ADDR byte (start address) -> CNT byte (word count; 0 means 2^ADDR_W, values above 2^ADDR_W are taken mod 2^ADDR_W) -> payload.
  - Program payload: HI byte, then LO byte per word.
  - Data payload: one byte per word.
- State machine: IDLE -> ADDR -> CNT -> (HI -> LO)* or (DB)* -> IDLE. With the optional feature, CSUM is inserted before the return to IDLE.
- Write timing: the byte that completes a word is accepted at edge k. The corresponding *_we is high for exactly cycle k+1, with addr/wdata valid in the same cycle.
- The address increments after each write and wraps from 2^ADDR_W-1 to 0. The remaining count decrements after each write; the frame ends when it reaches 0.
- Back-to-back bytes at full rate are supported. A new header may be accepted in the cycle in which the final write strobe is high.
- byte_valid low between bytes: state is held, no timeout.
- ena low: no transfer, no strobe, no counter change. A strobe already scheduled for the next cycle is still issued.
- prog_we and data_we are never high in the same cycle.

Optional Feature:
- Macro: N1_LOADER_CKSUM_EN.
- Defined: each load frame ends with one checksum byte, the 8-bit mod-256 sum of the ADDR, CNT and all payload bytes. On mismatch, err is set. Writes already issued are not undone, and later RUN headers are ignored until reset.
- Undefined: no checksum byte; the frame ends after the last payload byte and err is set only by bad headers.

Test Plan:
- Reset, then stream 00,00,01,00,01 -> prog_we pulses once with prog_addr=0 and prog_wdata=16'h0001; busy returns to 0; core_run=0.
- Data load 40,00,02,01,02 then RUN 80 -> data_we at addr 0 (wdata 01) and at addr 1 (wdata 02) on consecutive-byte cycles; core_run=1 one cycle after the 80 byte is accepted.
- Wrap: program load at address FE with count 03 -> writes to FE, FF, 00; 6 payload bytes consumed; busy low after the third write.
- Bad header 81 -> err=1, no strobes, core_run unchanged; the following 80 byte sets core_run=1.
- Assert rst_n low after the HI byte of a program word -> no prog_we, core_run=0, state IDLE; a fresh frame loads correctly after release.
- N1_LOADER_CKSUM_EN: frame 00,05,01,12,34 with checksum 4C -> write at 05 of 1234, err=0. Same frame with checksum 00 -> err=1 and a subsequent 80 byte leaves core_run=0.
